// File: rtl/veerwolf_sevseg_fmt.sv
// rtl/veerwolf_sevseg_fmt.sv - Wishbone number formatter driving four 7-segment digits
// Optional leading-zero blanking is compiled in with `SEVSEG_LZB_EN.
module veerwolf_sevseg_fmt (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic [6:0]  o_seg_digit0,
  output logic [6:0]  o_seg_digit1,
  output logic [6:0]  o_seg_digit2,
  output logic [6:0]  o_seg_digit3,
  output logic        o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ENCODE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] bcd_q, bcd_d;
  logic [13:0] bin_q, bin_d;
  logic [27:0] seg_q, seg_d;
  logic        ovf_q, ovf_d;
  logic [15:0] value_q;
  logic        mode_q, lat_mode_q, drop_q, ack_q;
  logic        blank_bit, lat_blank;
  logic [31:0] rdt_q, rd_mux;
  logic        reg_we, wr_value, wr_ctrl, idle, accept, drop_set;
  logic [15:0] nib, adj;
  logic [3:0]  lz;
  logic        unused_bits;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'h40;  4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;  4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;  4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;  4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;  4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;  4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;  4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;  default: seg_decode = 7'h0E;
    endcase
  endfunction

  assign unused_bits = ^{i_wb_adr[1:0], i_wb_sel[3:2], i_wb_dat[31:16]};

  assign idle     = (state_q == S_IDLE);
  assign reg_we   = i_wb_cyc & i_wb_stb & i_wb_we & ~ack_q;
  assign wr_value = reg_we & (i_wb_adr[3:2] == 2'd0);
  assign wr_ctrl  = reg_we & (i_wb_adr[3:2] == 2'd1);
  assign accept   = wr_value & idle & (&i_wb_sel[1:0]);
  assign drop_set = wr_value & ~idle;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  assign nib = lat_mode_q ? value_q : bcd_q;

`ifdef SEVSEG_LZB_EN
  logic blank_q, lat_blank_q;
  assign blank_bit = blank_q;
  assign lat_blank = lat_blank_q;
  always_comb begin
    lz    = 4'b0;
    lz[3] = lat_blank & (nib[15:12] == 4'd0);
    lz[2] = lz[3] & (nib[11:8] == 4'd0);
    lz[1] = lz[2] & (nib[7:4] == 4'd0);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      blank_q     <= 1'b0;
      lat_blank_q <= 1'b0;
    end else begin
      if (wr_ctrl & i_wb_sel[0]) blank_q <= i_wb_dat[1];
      if (accept) lat_blank_q <= blank_q;
    end
  end
`else
  assign blank_bit = 1'b0;
  assign lat_blank = 1'b0;
  assign lz        = 4'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    seg_d   = seg_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          bin_d   = i_wb_dat[13:0];
          bcd_d   = 16'd0;
          cnt_d   = 4'd0;
          state_d = mode_q ? S_ENCODE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) state_d = S_ENCODE;
      end
      S_ENCODE: begin
        ovf_d = ~lat_mode_q & (value_q > 16'd9999);
        if (ovf_d) seg_d = {4{7'h3F}};
        else
          for (int i = 0; i < 4; i++)
            seg_d[7*i +: 7] = lz[i] ? 7'h7F : seg_decode(nib[4*i +: 4]);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 32'd0;
    case (i_wb_adr[3:2])
      2'd0: rd_mux = {16'd0, value_q};
      2'd1: rd_mux = {21'd0, ovf_q, drop_q, ~idle, 6'd0, blank_bit, mode_q};
      2'd2: rd_mux = {4'd0, seg_q};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      bcd_q      <= 16'd0;
      bin_q      <= 14'd0;
      seg_q      <= {28{1'b1}};
      ovf_q      <= 1'b0;
      value_q    <= 16'd0;
      mode_q     <= 1'b0;
      lat_mode_q <= 1'b0;
      drop_q     <= 1'b0;
      ack_q      <= 1'b0;
      rdt_q      <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      seg_q   <= seg_d;
      ovf_q   <= ovf_d;
      ack_q   <= i_wb_cyc & i_wb_stb & ~ack_q;
      if (i_wb_cyc & i_wb_stb & ~ack_q) rdt_q <= rd_mux;
      if (accept) begin
        value_q    <= i_wb_dat[15:0];
        lat_mode_q <= mode_q;
      end
      if (wr_ctrl & i_wb_sel[0]) mode_q <= i_wb_dat[0];
      // A drop in the same cycle as a W1C clear keeps DROP set
      if (drop_set) drop_q <= 1'b1;
      else if (wr_ctrl & i_wb_sel[1] & i_wb_dat[9]) drop_q <= 1'b0;
    end
  end

  assign o_wb_rdt     = rdt_q;
  assign o_wb_ack     = ack_q;
  assign o_busy       = ~idle;
  assign o_seg_digit0 = seg_q[6:0];
  assign o_seg_digit1 = seg_q[13:7];
  assign o_seg_digit2 = seg_q[20:14];
  assign o_seg_digit3 = seg_q[27:21];

endmodule

// File: tb/tb_veerwolf_sevseg_fmt.sv
// tb/tb_veerwolf_sevseg_fmt.sv - directed vector bench for veerwolf_sevseg_fmt
module tb_veerwolf_sevseg_fmt;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [3:0]  i_wb_adr = 4'd0;
  logic [31:0] i_wb_dat = 32'd0;
  logic [3:0]  i_wb_sel = 4'd0;
  logic        i_wb_we = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic        i_wb_stb = 1'b0;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic [6:0]  o_seg_digit0, o_seg_digit1, o_seg_digit2, o_seg_digit3;
  logic        o_busy;
  logic [27:0] seg_all;

  int checks = 0;
  int errors = 0;
  logic [27:0] prev_seg;
  logic [31:0] rd;

  veerwolf_sevseg_fmt dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat),
    .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack), .o_seg_digit0(o_seg_digit0),
    .o_seg_digit1(o_seg_digit1), .o_seg_digit2(o_seg_digit2), .o_seg_digit3(o_seg_digit3),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;
  assign seg_all = {o_seg_digit3, o_seg_digit2, o_seg_digit1, o_seg_digit0};

  typedef struct {
    logic        mode;
    logic        blank;
    logic [15:0] val;
    logic [27:0] seg;
    logic        ovf;
  } vec_t;

  function automatic logic [27:0] s4(input logic [6:0] d3, d2, d1, d0);
    s4 = {d3, d2, d1, d0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wb_write(input logic [1:0] reg_idx, input logic [31:0] data);
    @(negedge i_clk);
    i_wb_adr = {reg_idx, 2'b00}; i_wb_dat = data; i_wb_sel = 4'hF;
    i_wb_we = 1'b1; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    @(negedge i_clk);
    chk("write_ack", {31'd0, o_wb_ack}, 32'd1);
    i_wb_we = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] reg_idx, output logic [31:0] data);
    @(negedge i_clk);
    i_wb_adr = {reg_idx, 2'b00}; i_wb_we = 1'b0; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    @(negedge i_clk);
    data = o_wb_rdt;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
  endtask

  task automatic run_conv(input vec_t v);
    logic blank_eff;
`ifdef SEVSEG_LZB_EN
    blank_eff = v.blank;
`else
    blank_eff = 1'b0;
`endif
    wb_write(2'd1, {30'd0, v.blank, v.mode});
    wb_write(2'd0, {16'd0, v.val});
    chk("busy_after_e0", {31'd0, o_busy}, 32'd1);
    repeat (v.mode ? 0 : 14) @(negedge i_clk);
    chk("busy_before_done", {31'd0, o_busy}, 32'd1);
    chk("seg_held", {4'd0, seg_all}, {4'd0, prev_seg});
    @(negedge i_clk);
    chk("busy_done", {31'd0, o_busy}, 32'd0);
    chk("seg_out", {4'd0, seg_all}, {4'd0, v.seg});
    prev_seg = v.seg;
    wb_read(2'd2, rd);
    chk("seg_reg", rd, {4'd0, v.seg});
    wb_read(2'd1, rd);
    chk("ctrl_status", rd, {21'd0, v.ovf, 8'd0, blank_eff, v.mode});
    wb_read(2'd0, rd);
    chk("value_rb", rd, {16'd0, v.val});
  endtask

  vec_t vecs[9];
  vec_t bvecs[4];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'd1234,  s4(7'h79, 7'h24, 7'h30, 7'h19), 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'hBEEF,  s4(7'h03, 7'h06, 7'h06, 7'h0E), 1'b0};
    vecs[2] = '{1'b0, 1'b0, 16'd10000, s4(7'h3F, 7'h3F, 7'h3F, 7'h3F), 1'b1};
    vecs[3] = '{1'b0, 1'b0, 16'd0,     s4(7'h40, 7'h40, 7'h40, 7'h40), 1'b0};
    vecs[4] = '{1'b0, 1'b0, 16'd9999,  s4(7'h10, 7'h10, 7'h10, 7'h10), 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'h0123,  s4(7'h40, 7'h79, 7'h24, 7'h30), 1'b0};
    vecs[6] = '{1'b0, 1'b0, 16'd5678,  s4(7'h12, 7'h02, 7'h78, 7'h00), 1'b0};
    vecs[7] = '{1'b1, 1'b0, 16'hA5C0,  s4(7'h08, 7'h12, 7'h46, 7'h40), 1'b0};
    vecs[8] = '{1'b0, 1'b0, 16'hFFFF,  s4(7'h3F, 7'h3F, 7'h3F, 7'h3F), 1'b1};
`ifdef SEVSEG_LZB_EN
    bvecs[0] = '{1'b0, 1'b1, 16'd7,     s4(7'h7F, 7'h7F, 7'h7F, 7'h78), 1'b0};
    bvecs[1] = '{1'b1, 1'b1, 16'h00A0,  s4(7'h7F, 7'h7F, 7'h08, 7'h40), 1'b0};
    bvecs[2] = '{1'b0, 1'b1, 16'd0,     s4(7'h7F, 7'h7F, 7'h7F, 7'h40), 1'b0};
`else
    bvecs[0] = '{1'b0, 1'b1, 16'd7,     s4(7'h40, 7'h40, 7'h40, 7'h78), 1'b0};
    bvecs[1] = '{1'b1, 1'b1, 16'h00A0,  s4(7'h40, 7'h40, 7'h08, 7'h40), 1'b0};
    bvecs[2] = '{1'b0, 1'b1, 16'd0,     s4(7'h40, 7'h40, 7'h40, 7'h40), 1'b0};
`endif
    bvecs[3] = '{1'b0, 1'b1, 16'd10000, s4(7'h3F, 7'h3F, 7'h3F, 7'h3F), 1'b1};

    // Reset held for two edges
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_seg", {4'd0, seg_all}, {4'd0, {28{1'b1}}});
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("rst_rdt", o_wb_rdt, 32'd0);
    wb_read(2'd1, rd);
    chk("rst_ctrl", rd, 32'd0);
    wb_read(2'd3, rd);
    chk("reg_c_zero", rd, 32'd0);
    prev_seg = {28{1'b1}};

    for (int i = 0; i < 9; i++) run_conv(vecs[i]);
    for (int i = 0; i < 4; i++) run_conv(bvecs[i]);

    // Write to VALUE while a decimal conversion is in flight
    wb_write(2'd1, 32'd0);
    wb_write(2'd0, 32'd42);
    repeat (3) @(negedge i_clk);
    wb_write(2'd0, 32'd99);
    repeat (9) @(negedge i_clk);
    chk("busy_e14", {31'd0, o_busy}, 32'd1);
    @(negedge i_clk);
    chk("busy_e15", {31'd0, o_busy}, 32'd0);
    chk("drop_seg", {4'd0, seg_all}, {4'd0, s4(7'h40, 7'h40, 7'h19, 7'h24)});
    wb_read(2'd1, rd);
    chk("drop_set", rd, 32'h200);
    wb_read(2'd0, rd);
    chk("drop_value", rd, 32'd42);
    wb_write(2'd1, 32'h200);
    wb_read(2'd1, rd);
    chk("drop_clr", rd, 32'd0);

    // Reset asserted so that edge E8 of a conversion samples it
    wb_write(2'd0, 32'd5555);
    repeat (7) @(negedge i_clk);
    chk("abort_busy_pre", {31'd0, o_busy}, 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("abort_seg", {4'd0, seg_all}, {4'd0, {28{1'b1}}});
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    i_rst = 1'b0;
    repeat (16) @(negedge i_clk);
    chk("abort_no_late", {4'd0, seg_all}, {4'd0, {28{1'b1}}});
    wb_read(2'd0, rd);
    chk("abort_value", rd, 32'd0);
    wb_read(2'd1, rd);
    chk("abort_ctrl", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
